// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, addresses the combinational ROM and
// queues {pc, instr} pairs in a prefetch FIFO for decode.
module fetch_unit #(
    parameter int          DEPTH    = 4,
    parameter int          MEM_SIZE = 1024,
    parameter logic [63:0] RESET_PC = 64'h0
) (
    input  logic        clk,
    input  logic        reset_n,
    output logic [63:0] imem_addr,
    input  logic [31:0] imem_instr,
    input  logic        redirect_valid,
    input  logic [63:0] redirect_target,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [63:0] out_pc,
    output logic        fetch_fault
);

    localparam int          PW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int          CW        = PW + 1;
    localparam logic [CW-1:0] FULL    = CW'(DEPTH);
    localparam logic [63:0] MEM_LIMIT = 64'(MEM_SIZE);

    logic [63:0]   pc;
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [CW-1:0] count;
    logic [63:0]   fifo_pc    [DEPTH];
    logic [31:0]   fifo_instr [DEPTH];

    logic fetch_ok;
    logic pop;
    logic push;

    // Aligned word lies wholly inside the ROM; an aligned address cannot wrap on +3.
    function automatic logic addr_ok(input logic [63:0] a);
        return (a[1:0] == 2'b00) && ((a + 64'd3) < MEM_LIMIT);
    endfunction

    assign fetch_ok = !fetch_fault && addr_ok(pc);
    assign pop      = out_valid && out_ready;
    assign push     = fetch_ok && !redirect_valid && ((count < FULL) || pop);

    assign imem_addr = pc;
    assign out_valid = (count != '0);
    assign out_pc    = out_valid ? fifo_pc[rd_ptr]    : 64'h0;
    assign out_instr = out_valid ? fifo_instr[rd_ptr] : 32'h0;

    // NOTE: the storage array has no reset; out_valid gates the head, so stale
    // contents are never observable and the array maps onto plain registers/RAM.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_pc[wr_ptr]    <= pc;
            fifo_instr[wr_ptr] <= imem_instr;
        end
    end

    // NOTE: all state uses non-blocking assignments so every register samples
    // the pre-edge values of push/pop/pc regardless of statement order.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pc          <= RESET_PC;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            count       <= '0;
            fetch_fault <= 1'b0;
        end else if (redirect_valid) begin
            // A pop this cycle has already been consumed by decode; the flush
            // simply discards everything that remains.
            pc          <= redirect_target;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            count       <= '0;
            fetch_fault <= !addr_ok(redirect_target);
        end else begin
            if (push) begin
                pc     <= pc + 64'd4;
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
            if (!fetch_fault && !addr_ok(pc)) begin
                fetch_fault <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: streaming, backpressure, redirects, fault and
// asynchronous reset, against a ROM whose word at address a is 0xC0DE_<a[15:0]>.
module tb_fetch_unit;

    logic        clk;
    logic        reset_n;
    logic [63:0] imem_addr;
    logic [31:0] imem_instr;
    logic        redirect_valid;
    logic [63:0] redirect_target;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [63:0] out_pc;
    logic        fetch_fault;

    int n_tests = 0;
    int n_fail  = 0;

    fetch_unit #(.DEPTH(4), .MEM_SIZE(1024), .RESET_PC(64'h0)) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .imem_addr       (imem_addr),
        .imem_instr      (imem_instr),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .out_instr       (out_instr),
        .out_pc          (out_pc),
        .fetch_fault     (fetch_fault)
    );

    function automatic logic [31:0] rom_word(input logic [63:0] a);
        return {16'hC0DE, a[15:0]};
    endfunction

    assign imem_instr = rom_word(imem_addr);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input logic ready);
        reset_n         = 1'b0;
        out_ready       = ready;
        redirect_valid  = 1'b0;
        redirect_target = 64'h0;
        tick();
        tick();
        reset_n = 1'b1;
    endtask

    task automatic redirect(input logic [63:0] target);
        redirect_valid  = 1'b1;
        redirect_target = target;
        tick();
        redirect_valid  = 1'b0;
    endtask

    initial begin
        // Reset and stream
        do_reset(1'b1);
        check("rst_valid", 64'(out_valid), 64'h0);
        check("rst_addr",  imem_addr, 64'h0);
        check("rst_pc",    out_pc, 64'h0);
        check("rst_instr", 64'(out_instr), 64'h0);
        check("rst_fault", 64'(fetch_fault), 64'h0);
        for (int k = 0; k < 8; k++) begin
            tick();
            check("stream_valid", 64'(out_valid), 64'h1);
            check("stream_pc",    out_pc, 64'(4 * k));
            check("stream_instr", 64'(out_instr), 64'(32'hC0DE_0000 + 32'(4 * k)));
        end

        // Backpressure until full, then drain in consecutive cycles
        do_reset(1'b0);
        for (int k = 0; k < 6; k++) tick();
        check("full_addr",  imem_addr, 64'h10);
        check("full_pc",    out_pc, 64'h0);
        check("full_instr", 64'(out_instr), 64'hC0DE_0000);
        out_ready = 1'b1;
        check("drain_pc0", out_pc, 64'h0);
        for (int k = 1; k <= 4; k++) begin
            tick();
            check("drain_valid", 64'(out_valid), 64'h1);
            check("drain_pc",    out_pc, 64'(4 * k));
        end

        // Redirect with concurrent pop of head 0x8
        do_reset(1'b1);
        tick();
        tick();
        tick();
        check("redir_head", out_pc, 64'h8);
        redirect(64'h40);
        check("redir_flush", 64'(out_valid), 64'h0);
        check("redir_addr",  imem_addr, 64'h40);
        tick();
        check("redir_valid", 64'(out_valid), 64'h1);
        check("redir_pc",    out_pc, 64'h40);
        check("redir_instr", 64'(out_instr), 64'hC0DE_0040);

        // Misaligned redirect, then recovery
        redirect(64'h42);
        check("mis_fault", 64'(fetch_fault), 64'h1);
        check("mis_valid", 64'(out_valid), 64'h0);
        tick();
        tick();
        check("mis_hold_valid", 64'(out_valid), 64'h0);
        check("mis_hold_addr",  imem_addr, 64'h42);
        redirect(64'h20);
        check("rec_fault", 64'(fetch_fault), 64'h0);
        check("rec_addr",  imem_addr, 64'h20);
        tick();
        check("rec_pc0", out_pc, 64'h20);
        tick();
        check("rec_pc1", out_pc, 64'h24);

        // End of ROM
        out_ready = 1'b0;
        redirect(64'h3F8);
        check("eor_flush", 64'(out_valid), 64'h0);
        tick();
        tick();
        tick();
        check("eor_fault", 64'(fetch_fault), 64'h1);
        check("eor_addr",  imem_addr, 64'h400);
        tick();
        check("eor_pc_hold", imem_addr, 64'h400);
        check("eor_head",    out_pc, 64'h3F8);
        out_ready = 1'b1;
        tick();
        check("eor_second", out_pc, 64'h3FC);
        check("eor_second_instr", 64'(out_instr), 64'hC0DE_03FC);
        tick();
        check("eor_empty", 64'(out_valid), 64'h0);
        check("eor_fault_sticky", 64'(fetch_fault), 64'h1);

        // Asynchronous reset between edges with three entries queued
        out_ready = 1'b0;
        redirect(64'h0);
        check("ar_fault_clr", 64'(fetch_fault), 64'h0);
        tick();
        tick();
        tick();
        check("ar_pre_addr",  imem_addr, 64'hC);
        check("ar_pre_valid", 64'(out_valid), 64'h1);
        #2;
        reset_n = 1'b0;
        #1;
        check("ar_valid", 64'(out_valid), 64'h0);
        check("ar_addr",  imem_addr, 64'h0);
        check("ar_pc",    out_pc, 64'h0);
        tick();
        reset_n   = 1'b1;
        out_ready = 1'b1;
        tick();
        check("ar_stream0", out_pc, 64'h0);
        tick();
        check("ar_stream1", out_pc, 64'h4);
        check("ar_stream1_instr", 64'(out_instr), 64'hC0DE_0004);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
